// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with credit-limited memory requests and an in-order buffer.
// Define FETCH_PERF_EN to add the bubble and dropped-response performance counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        ValidF
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_bubble_cnt,
    output logic [31:0] perf_drop_cnt
`endif
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [PTR_W-1:0] ptr_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    logic [31:0] pc_q;
    entry_t      ibuf_q [DEPTH];
    ptr_t        ibuf_head, ibuf_tail;
    cnt_t        count;
    logic [31:0] ifq_pc [DEPTH];
    ptr_t        ifq_head, ifq_tail;
    cnt_t        inflight, drop;

    logic credit_ok, accept, rsp_keep, rsp_discard, pop;
    cnt_t inflight_left;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        credit_ok      = ({1'b0, inflight} + {1'b0, count}) < CREDITS;
        imem_req_valid = !reset && !PCSrcE && credit_ok;
        imem_req_addr  = pc_q;
        accept         = imem_req_valid && imem_req_ready;
        rsp_discard    = imem_rsp_valid && (PCSrcE || drop != '0);
        rsp_keep       = imem_rsp_valid && !PCSrcE && drop == '0;
        pop            = !StallF && !PCSrcE && count != '0;
        inflight_left  = (imem_rsp_valid && inflight != '0) ? inflight - cnt_t'(1) : inflight;

        InstrF   = NOP;
        PCF      = '0;
        PCPlus4F = '0;
        ValidF   = 1'b0;
        if (count != '0) begin
            InstrF   = ibuf_q[ibuf_head].instr;
            PCF      = ibuf_q[ibuf_head].pc;
            PCPlus4F = ibuf_q[ibuf_head].pc + 32'd4;
            ValidF   = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            ibuf_head <= '0;
            ibuf_tail <= '0;
            count     <= '0;
            ifq_head  <= '0;
            ifq_tail  <= '0;
            inflight  <= '0;
            drop      <= '0;
        end else if (PCSrcE) begin
            // Everything still outstanding belongs to the wrong path and is dropped on return.
            pc_q      <= PCTargetE & 32'hFFFF_FFFC;
            ibuf_head <= '0;
            ibuf_tail <= '0;
            count     <= '0;
            ifq_head  <= '0;
            ifq_tail  <= '0;
            inflight  <= inflight_left;
            drop      <= inflight_left;
        end else begin
            if (accept) begin
                pc_q     <= pc_q + 32'd4;
                ifq_tail <= ptr_inc(ifq_tail);
            end
            if (rsp_keep) begin
                ibuf_tail <= ptr_inc(ibuf_tail);
                ifq_head  <= ptr_inc(ifq_head);
            end
            if (pop) ibuf_head <= ptr_inc(ibuf_head);
            if (imem_rsp_valid && drop != '0) drop <= drop - cnt_t'(1);

            case ({accept, imem_rsp_valid})
                2'b10:   inflight <= inflight + cnt_t'(1);
                2'b01:   inflight <= inflight - cnt_t'(1);
                default: inflight <= inflight;
            endcase

            case ({rsp_keep, pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage arrays have no reset; pointers and counters alone define which entries are live.
    always_ff @(posedge clk) begin
        if (accept) ifq_pc[ifq_tail] <= pc_q;
        if (rsp_keep) begin
            ibuf_q[ibuf_tail].instr <= imem_rsp_data;
            ibuf_q[ibuf_tail].pc    <= ifq_pc[ifq_head];
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_bubble_cnt <= '0;
            perf_drop_cnt   <= '0;
        end else begin
            if (!StallF && !PCSrcE && count == '0) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            if (rsp_discard) perf_drop_cnt <= perf_drop_cnt + 32'd1;
        end
    end
`endif

endmodule
